// File: rtl/vit_pkg.sv
// Shared helpers for the parametrised Viterbi decoder: trellis sizing,
// generator parity, initial path-metric value and the frame FSM encoding.
package vit_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fsm_t;

  // Number of trellis states for constraint length k.
  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  // Metric given to every non-zero state at start so decoding begins in state 0.
  function automatic int pm_init(input int pm_w);
    return 1 << (pm_w - 2);
  endfunction

  // XOR-reduction of a word, used on (generator & encoder register).
  function automatic int parity(input int v);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) begin
      p = p ^ ((v >> i) & 1);
    end
    return p;
  endfunction

  // Expected code pair {c0,c1} as a 2-bit index for a given encoder register value.
  function automatic int code_pair(input int enc, input int g0, input int g1);
    return (parity(enc & g0) << 1) | parity(enc & g1);
  endfunction

endpackage

// File: rtl/viterbi_dec_param_if.sv
// Symbol-in / bit-out bundle of the Viterbi decoder.
// The master drives received symbols; the slave (decoder) returns decoded bits.
interface viterbi_dec_param_if #(
  parameter int SOFT_W = 1
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2*SOFT_W-1:0]   rx;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_bit;
  logic                  out_last;

  modport master (
    output in_valid, rx, in_last,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, rx, in_last,
    output in_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/vit_acs_unit.sv
// Add-compare-select for one trellis state: adds each predecessor metric to
// its branch metric with saturation, keeps the strictly smaller candidate
// (ties go to predecessor x=0) and reports which predecessor won.
module vit_acs_unit #(
  parameter int PM_W = 8,
  parameter int BM_W = 2
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [BM_W-1:0] bm0_i,
  input  logic [BM_W-1:0] bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);
  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  // Saturating add of both candidates, then compare and select.
  always_comb begin
    sum0  = {1'b0, pm0_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm0_i};
    sum1  = {1'b0, pm1_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm1_i};
    cand0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
    cand1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
    dec_o = (cand1 < cand0);
    pm_o  = dec_o ? cand1 : cand0;
  end
endmodule

// File: rtl/viterbi_dec_param.sv
// Parametrised rate-1/2 Viterbi decoder with register-exchange survivors.
// One symbol per accepted beat; one decoded bit per beat once the survivor
// registers are full. Optional frame flush (zero-tail drain) is built when
// the macro VIT_FLUSH_EN is defined; otherwise the decoder streams only.
module viterbi_dec_param
  import vit_pkg::*;
#(
  parameter int K        = 3,
  parameter int G0       = 'o7,
  parameter int G1       = 'o5,
  parameter int SOFT_W   = 1,
  parameter int PM_W     = 8,
  parameter int TB_DEPTH = 15
) (
  input logic clk,
  input logic rst,
  viterbi_dec_param_if.slave bus
);
  localparam int NS    = num_states(K);
  localparam int SW    = K - 1;
  localparam int BM_W  = SOFT_W + 1;
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(pm_init(PM_W));
  localparam logic [SOFT_W-1:0] S_MAX    = {SOFT_W{1'b1}};
  localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0]  FILL_LIM = CNT_W'(TB_DEPTH - 1);

  logic [SOFT_W-1:0]   smp0;
  logic [SOFT_W-1:0]   smp1;
  logic [BM_W-1:0]     bm_tab [4];
  logic [PM_W-1:0]     pm_q [NS];
  logic [PM_W-1:0]     pm_d [NS];
  logic [PM_W-1:0]     pm_acs [NS];
  logic [PM_W-1:0]     pm_min;
  logic                dec [NS];
  logic [TB_DEPTH-1:0] path_q [NS];
  logic [TB_DEPTH-1:0] path_d [NS];
  logic [TB_DEPTH-1:0] path_new [NS];
  logic [SW-1:0]       best;
  logic [CNT_W-1:0]    fill_q, fill_d, fill_inc;
  logic                out_valid_q, out_valid_d;
  logic                out_bit_q, out_bit_d;
  logic                in_ready;
  logic                beat;

`ifdef VIT_FLUSH_EN
  fsm_t                state_q, state_d;
  logic [TB_DEPTH-1:0] drain_buf_q, drain_buf_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                out_last_q, out_last_d;

  assign in_ready     = (state_q == RUN);
  assign bus.out_last = out_last_q;
`else
  logic unused_last;

  assign unused_last  = bus.in_last;
  assign in_ready     = 1'b1;
  assign bus.out_last = 1'b0;
`endif

  assign smp0          = bus.rx[2*SOFT_W-1:SOFT_W];
  assign smp1          = bus.rx[SOFT_W-1:0];
  assign beat          = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;

  // Branch metric for each of the four expected code pairs {c0,c1};
  // hard decision is simply the SOFT_W=1 case of the distance sum.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bm
    localparam logic EXP0 = ((gi >> 1) & 1) != 0;
    localparam logic EXP1 = (gi & 1) != 0;
    logic [SOFT_W-1:0] d0;
    logic [SOFT_W-1:0] d1;
    assign d0         = EXP0 ? (S_MAX - smp0) : smp0;
    assign d1         = EXP1 ? (S_MAX - smp1) : smp1;
    assign bm_tab[gi] = {1'b0, d0} + {1'b0, d1};
  end

  // One ACS per next state; predecessors are {ns[K-3:0],x} and the
  // encoder register for that branch is {ns,x}.
  for (genvar gi = 0; gi < NS; gi++) begin : g_acs
    localparam int   P0      = (gi << 1) & (NS - 1);
    localparam int   P1      = P0 | 1;
    localparam int   C0      = code_pair(gi << 1, G0, G1);
    localparam int   C1      = code_pair((gi << 1) | 1, G0, G1);
    localparam logic NEW_BIT = ((gi >> (K - 2)) & 1) != 0;

    vit_acs_unit #(
      .PM_W (PM_W),
      .BM_W (BM_W)
    ) u_acs (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm_tab[C0]),
      .bm1_i (bm_tab[C1]),
      .pm_o  (pm_acs[gi]),
      .dec_o (dec[gi])
    );

    assign path_new[gi] = {dec[gi] ? path_q[P1][TB_DEPTH-2:0] : path_q[P0][TB_DEPTH-2:0],
                           NEW_BIT};
  end

  // Minimum new metric and the lowest-index state holding it.
  always_comb begin
    pm_min = pm_acs[0];
    best   = '0;
    for (int i = 1; i < NS; i++) begin
      if (pm_acs[i] < pm_min) begin
        pm_min = pm_acs[i];
        best   = SW'(i);
      end
    end
  end

  // Next-state logic: metric/survivor update per beat, output selection,
  // frame drain sequencing.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pm_d[i]   = pm_q[i];
      path_d[i] = path_q[i];
    end
    fill_d      = fill_q;
    fill_inc    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
`ifdef VIT_FLUSH_EN
    state_d     = state_q;
    drain_buf_d = drain_buf_q;
    drain_cnt_d = drain_cnt_q;
    out_last_d  = 1'b0;
`endif

    if (beat) begin
      for (int i = 0; i < NS; i++) begin
        pm_d[i]   = pm_acs[i] - pm_min;
        path_d[i] = path_new[i];
      end
      fill_d = fill_inc;
      if (fill_inc >= FILL_MAX) begin
        out_valid_d = 1'b1;
        out_bit_d   = path_new[best][TB_DEPTH-1];
      end
`ifdef VIT_FLUSH_EN
      if (bus.in_last) begin
        // Zero-tail frame: the state-0 survivor is the decoded frame. Align
        // the oldest not-yet-emitted bit to the MSB and restart the trellis.
        state_d     = DRAIN;
        drain_cnt_d = (fill_inc > FILL_LIM) ? FILL_LIM : fill_inc;
        drain_buf_d = path_new[0] << (FILL_MAX - drain_cnt_d);
        fill_d      = '0;
        for (int i = 0; i < NS; i++) begin
          pm_d[i]   = (i == 0) ? '0 : PM_INIT;
          path_d[i] = '0;
        end
      end
`endif
    end

`ifdef VIT_FLUSH_EN
    if (state_q == DRAIN) begin
      out_valid_d = 1'b1;
      out_bit_d   = drain_buf_q[TB_DEPTH-1];
      out_last_d  = (drain_cnt_q == CNT_W'(1));
      drain_buf_d = drain_buf_q << 1;
      drain_cnt_d = drain_cnt_q - 1'b1;
      if (drain_cnt_q == CNT_W'(1)) begin
        state_d = RUN;
      end
    end
`endif
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        path_q[i] <= '0;
      end
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
`ifdef VIT_FLUSH_EN
      state_q     <= RUN;
      drain_buf_q <= '0;
      drain_cnt_q <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= pm_d[i];
        path_q[i] <= path_d[i];
      end
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
`ifdef VIT_FLUSH_EN
      state_q     <= state_d;
      drain_buf_q <= drain_buf_d;
      drain_cnt_q <= drain_cnt_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

endmodule
